// File: rtl/verifier_horner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : verifier_horner_pkg
// Description : Shared field constants, FSM state encoding and helpers for
//               the multi-lane Horner evaluator.
// Revision    : 1.0 - initial release
// ============================================================================
package verifier_horner_pkg;

    // Field: integers modulo the largest 16-bit prime.
    localparam int                F_NBITS = 16;
    localparam logic [F_NBITS-1:0] F_Q    = 16'd65521;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Bit width needed to index n items (at least one bit).
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // (a + b) mod F_Q for a, b < F_Q.
    function automatic logic [F_NBITS-1:0] add_mod(input logic [F_NBITS-1:0] a,
                                                   input logic [F_NBITS-1:0] b);
        logic [F_NBITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, F_Q})
            s = s - {1'b0, F_Q};
        return F_NBITS'(s);
    endfunction

endpackage
`default_nettype wire

// File: rtl/verifier_compute_horner_multi_muladd.sv
`default_nettype none
// ============================================================================
// Module      : field_muladd
// Description : (a*b + c) mod F_Q, fully registered over mulLat stages.
// Revision    : 1.0 - initial release
// ============================================================================
module field_muladd
    import verifier_horner_pkg::*;
#(
    parameter int mulLat = 1
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic [F_NBITS-1:0] a,
    input  logic [F_NBITS-1:0] b,
    input  logic [F_NBITS-1:0] c,
    output logic [F_NBITS-1:0] y
);

    localparam int c_PW = 2 * F_NBITS + 1;

    logic [c_PW-1:0]    w_full;
    logic [F_NBITS-1:0] w_red;
    logic [F_NBITS-1:0] r_pipe [mulLat];

    always_comb begin
        w_full = c_PW'(a) * c_PW'(b) + c_PW'(c);
        w_red  = F_NBITS'(w_full % c_PW'(F_Q));
    end

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            for (int i = 0; i < mulLat; i++)
                r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= w_red;
            for (int i = 1; i < mulLat; i++)
                r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign y = r_pipe[mulLat-1];

endmodule
`default_nettype wire

// File: rtl/verifier_compute_horner_multi.sv
`default_nettype none
// ============================================================================
// Module      : verifier_compute_horner_multi
// Description : Iterative multi-lane Horner evaluator with sumcheck identity
//               check p(0)+p(1) == claim and a sticky failure flag.
// Revision    : 1.0 - initial release
// ============================================================================
module verifier_compute_horner_multi
    import verifier_horner_pkg::*;
#(
    parameter int maxDegree = 9,
    parameter int nLanes    = 4,
    parameter int mulLat    = 1
) (
    input  logic                                  clk,
    input  logic                                  rstb,
    input  logic                                  en,
    input  logic                                  restart,
    input  logic                                  chain,
    input  logic [width_of(maxDegree+1)-1:0]      ncoeff,
    input  logic [F_NBITS-1:0]                    tau,
    input  logic [F_NBITS-1:0]                    c_in [nLanes][maxDegree+1],
    input  logic [F_NBITS-1:0]                    val_in [nLanes],
    output logic [F_NBITS-1:0]                    val_out [nLanes],
    output logic [F_NBITS-1:0]                    v2_out [nLanes],
    output logic [nLanes-1:0]                     ok,
    output logic                                  ok_all,
    output logic                                  fail,
    output logic                                  ready
);

    localparam int              c_KW    = width_of(maxDegree + 1);
    localparam int              c_WW    = width_of(mulLat);
    localparam logic [c_KW-1:0] c_MAXD  = c_KW'(maxDegree);
    localparam logic [c_WW-1:0] c_WLAST = c_WW'(mulLat - 1);

    state_t             r_state;
    logic [c_KW-1:0]    r_k;
    logic [c_WW-1:0]    r_wcnt;
    logic [F_NBITS-1:0] r_tau;
    logic [F_NBITS-1:0] r_c   [nLanes][maxDegree+1];
    logic [F_NBITS-1:0] r_acc [nLanes];
    logic [F_NBITS-1:0] r_sum [nLanes];
    logic [F_NBITS-1:0] r_exp [nLanes];

    logic [c_KW-1:0]    w_d;
    logic               w_accept;
    logic [nLanes-1:0]  w_ok;
    logic [F_NBITS-1:0] w_mres [nLanes];

    always_comb begin
        w_d      = (ncoeff > c_MAXD) ? c_MAXD : ncoeff;
        w_accept = en & ready;
        for (int l = 0; l < nLanes; l++)
            w_ok[l] = (r_sum[l] == r_exp[l]);
    end

    generate
        for (genvar l = 0; l < nLanes; l++) begin : g_lane
            field_muladd #(.mulLat(mulLat)) u_muladd (
                .clk  (clk),
                .rstb (rstb),
                .a    (r_acc[l]),
                .b    (r_tau),
                .c    (r_c[l][r_k]),
                .y    (w_mres[l])
            );
        end
    endgenerate

    // DONE with ready low is the one-cycle result-commit step.
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_wcnt  <= '0;
            r_tau   <= '0;
            ok      <= '0;
            ok_all  <= 1'b0;
            fail    <= 1'b0;
            ready   <= 1'b1;
            for (int l = 0; l < nLanes; l++) begin
                r_acc[l]   <= '0;
                r_sum[l]   <= '0;
                r_exp[l]   <= '0;
                val_out[l] <= '0;
                v2_out[l]  <= '0;
                for (int j = 0; j <= maxDegree; j++)
                    r_c[l][j] <= '0;
            end
        end else if (w_accept) begin
            r_tau  <= tau;
            r_k    <= (w_d == '0) ? '0 : w_d - 1'b1;
            r_wcnt <= '0;
            ready  <= 1'b0;
            if (restart)
                fail <= 1'b0;
            for (int l = 0; l < nLanes; l++) begin
                r_c[l]   <= c_in[l];
                r_acc[l] <= c_in[l][w_d];
                r_sum[l] <= add_mod(c_in[l][0], c_in[l][w_d]);
                r_exp[l] <= chain ? val_out[l] : val_in[l];
            end
            r_state <= (w_d == '0) ? ST_DONE : ST_STEP;
        end else begin
            case (r_state)
                ST_STEP: begin
                    for (int l = 0; l < nLanes; l++)
                        r_sum[l] <= add_mod(r_sum[l], r_c[l][r_k]);
                    r_wcnt  <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_wcnt == c_WLAST) begin
                        for (int l = 0; l < nLanes; l++)
                            r_acc[l] <= w_mres[l];
                        if (r_k == '0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_k     <= r_k - 1'b1;
                            r_state <= ST_STEP;
                        end
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!ready) begin
                        for (int l = 0; l < nLanes; l++) begin
                            val_out[l] <= r_acc[l];
                            v2_out[l]  <= r_sum[l];
                        end
                        ok     <= w_ok;
                        ok_all <= &w_ok;
                        fail   <= fail | ~(&w_ok);
                        ready  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_verifier_compute_horner_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_verifier_compute_horner_multi
// Description : Directed self-checking bench for the multi-lane Horner evaluator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_verifier_compute_horner_multi;

    localparam int Q = 65521;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        en = 1'b0;
    logic        en3 = 1'b0;
    logic        restart = 1'b0;
    logic        chain = 1'b0;
    logic [3:0]  ncoeff = '0;
    logic [15:0] tau = '0;
    logic [15:0] c_in [4][10];
    logic [15:0] val_in [4];

    logic [15:0] val_out1 [4];
    logic [15:0] v2_out1 [4];
    logic [3:0]  ok1;
    logic        ok_all1, fail1, ready1;
    logic [15:0] val_out3 [4];
    logic [15:0] v2_out3 [4];
    logic [3:0]  ok3;
    logic        ok_all3, fail3, ready3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    verifier_compute_horner_multi #(.maxDegree(9), .nLanes(4), .mulLat(1)) dut1 (
        .clk(clk), .rstb(rstb), .en(en), .restart(restart), .chain(chain),
        .ncoeff(ncoeff), .tau(tau), .c_in(c_in), .val_in(val_in),
        .val_out(val_out1), .v2_out(v2_out1), .ok(ok1), .ok_all(ok_all1),
        .fail(fail1), .ready(ready1)
    );

    verifier_compute_horner_multi #(.maxDegree(9), .nLanes(4), .mulLat(3)) dut3 (
        .clk(clk), .rstb(rstb), .en(en3), .restart(restart), .chain(chain),
        .ncoeff(ncoeff), .tau(tau), .c_in(c_in), .val_in(val_in),
        .val_out(val_out3), .v2_out(v2_out3), .ok(ok3), .ok_all(ok_all3),
        .fail(fail3), .ready(ready3)
    );

    // Same low-order coefficients on every lane, rest zero.
    task automatic set_poly(input logic [15:0] c0, input logic [15:0] c1,
                            input logic [15:0] c2, input logic [15:0] v);
        for (int l = 0; l < 4; l++) begin
            for (int j = 0; j < 10; j++) c_in[l][j] = 16'd0;
            c_in[l][0] = c0; c_in[l][1] = c1; c_in[l][2] = c2;
            val_in[l] = v;
        end
    endtask

    // Accept one evaluation on dut1 and count cycles until ready rises.
    task automatic run_eval(input logic [3:0] nc, input logic rs, input logic ch,
                            output logic rdy_after_accept, output int lat);
        @(negedge clk);
        ncoeff = nc; restart = rs; chain = ch; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        rdy_after_accept = ready1;
        lat = 0;
        while (lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (ready1) break;
        end
    endtask

    function automatic int model_val(input int lane, input int d, input int t);
        longint unsigned acc;
        acc = c_in[lane][d];
        for (int k = d - 1; k >= 0; k--)
            acc = (acc * longint'(t) + c_in[lane][k]) % Q;
        return int'(acc);
    endfunction

    function automatic int model_v2(input int lane, input int d);
        longint unsigned s;
        s = c_in[lane][0];
        for (int k = 0; k <= d; k++) s = (s + c_in[lane][k]) % Q;
        return int'(s);
    endfunction

    task automatic test_reset;
        rstb = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); rstb = 1'b0;
        @(negedge clk);
        n_tests++; if (ready1 !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready1); end
        n_tests++; if (val_out1[0] !== 16'd0) begin n_fail++; $display("FAIL reset_val got %0d want 0", val_out1[0]); end
        n_tests++; if (v2_out1[0] !== 16'd0) begin n_fail++; $display("FAIL reset_v2 got %0d want 0", v2_out1[0]); end
        n_tests++; if (ok1 !== 4'h0) begin n_fail++; $display("FAIL reset_ok got %h want 0", ok1); end
        n_tests++; if (ok_all1 !== 1'b0) begin n_fail++; $display("FAIL reset_ok_all got %b want 0", ok_all1); end
        n_tests++; if (fail1 !== 1'b0) begin n_fail++; $display("FAIL reset_fail got %b want 0", fail1); end
    endtask

    task automatic test_basic;
        logic r; int lat;
        set_poly(16'd3, 16'd2, 16'd1, 16'd9); tau = 16'd5;
        run_eval(4'd2, 1'b0, 1'b0, r, lat);
        n_tests++; if (r !== 1'b0) begin n_fail++; $display("FAIL basic_busy got %b want 0", r); end
        n_tests++; if (lat != 5) begin n_fail++; $display("FAIL basic_latency got %0d want 5", lat); end
        n_tests++; if (val_out1[0] !== 16'd38) begin n_fail++; $display("FAIL basic_val got %0d want 38", val_out1[0]); end
        n_tests++; if (v2_out1[0] !== 16'd9) begin n_fail++; $display("FAIL basic_v2 got %0d want 9", v2_out1[0]); end
        n_tests++; if (ok1 !== 4'hF) begin n_fail++; $display("FAIL basic_ok got %h want f", ok1); end
        n_tests++; if (ok_all1 !== 1'b1) begin n_fail++; $display("FAIL basic_ok_all got %b want 1", ok_all1); end
    endtask

    task automatic test_wrap;
        logic r; int lat;
        set_poly(16'(Q - 1), 16'd1, 16'd0, 16'(Q - 1)); tau = 16'd1;
        run_eval(4'd1, 1'b0, 1'b0, r, lat);
        n_tests++; if (lat != 3) begin n_fail++; $display("FAIL wrap_latency got %0d want 3", lat); end
        n_tests++; if (val_out1[2] !== 16'd0) begin n_fail++; $display("FAIL wrap_val got %0d want 0", val_out1[2]); end
        n_tests++; if (v2_out1[2] !== 16'(Q - 1)) begin n_fail++; $display("FAIL wrap_v2 got %0d want %0d", v2_out1[2], Q - 1); end
    endtask

    task automatic test_degree0;
        logic r; int lat;
        set_poly(16'd4, 16'd7, 16'd7, 16'd8); tau = 16'd3;
        run_eval(4'd0, 1'b0, 1'b0, r, lat);
        n_tests++; if (lat != 1) begin n_fail++; $display("FAIL deg0_latency got %0d want 1", lat); end
        n_tests++; if (val_out1[1] !== 16'd4) begin n_fail++; $display("FAIL deg0_val got %0d want 4", val_out1[1]); end
        n_tests++; if (v2_out1[1] !== 16'd8) begin n_fail++; $display("FAIL deg0_v2 got %0d want 8", v2_out1[1]); end
        n_tests++; if (ok_all1 !== 1'b1) begin n_fail++; $display("FAIL deg0_ok_all got %b want 1", ok_all1); end
    endtask

    // c[i] = i+1, tau = 2: p(2) = 9*2^10 + 1 = 9217, p(0)+p(1) = 1 + 55 = 56.
    task automatic test_clamp;
        logic r; int lat;
        for (int l = 0; l < 4; l++) begin
            for (int j = 0; j < 10; j++) c_in[l][j] = 16'(j + 1);
            val_in[l] = 16'd56;
        end
        tau = 16'd2;
        run_eval(4'd15, 1'b0, 1'b0, r, lat);
        n_tests++; if (lat != 19) begin n_fail++; $display("FAIL clamp_latency got %0d want 19", lat); end
        n_tests++; if (val_out1[3] !== 16'd9217) begin n_fail++; $display("FAIL clamp_val got %0d want 9217", val_out1[3]); end
        n_tests++; if (v2_out1[3] !== 16'd56) begin n_fail++; $display("FAIL clamp_v2 got %0d want 56", v2_out1[3]); end
    endtask

    task automatic test_busy;
        int lat;
        set_poly(16'd3, 16'd2, 16'd1, 16'd9); tau = 16'd5;
        @(negedge clk); ncoeff = 4'd2; restart = 1'b0; chain = 1'b0; en = 1'b1;
        @(posedge clk); #1; en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        en = 1'b1; ncoeff = 4'd0;
        for (int l = 0; l < 4; l++) c_in[l][0] = 16'd777;
        @(posedge clk); #1; en = 1'b0;
        lat = 2;
        while (!ready1 && lat < 200) begin @(posedge clk); #1; lat++; end
        n_tests++; if (lat != 5) begin n_fail++; $display("FAIL busy_latency got %0d want 5", lat); end
        n_tests++; if (val_out1[0] !== 16'd38) begin n_fail++; $display("FAIL busy_val got %0d want 38", val_out1[0]); end
    endtask

    task automatic test_chain_fail;
        logic r; int lat;
        set_poly(16'd3, 16'd2, 16'd1, 16'd9); tau = 16'd5;
        run_eval(4'd2, 1'b1, 1'b0, r, lat);
        n_tests++; if (val_out1[0] !== 16'd38) begin n_fail++; $display("FAIL chain_r1_val got %0d want 38", val_out1[0]); end
        set_poly(16'd19, 16'd0, 16'd0, 16'd0);
        run_eval(4'd1, 1'b0, 1'b1, r, lat);
        n_tests++; if (ok1 !== 4'hF) begin n_fail++; $display("FAIL chain_r2_ok got %h want f", ok1); end
        n_tests++; if (val_out1[0] !== 16'd19) begin n_fail++; $display("FAIL chain_r2_val got %0d want 19", val_out1[0]); end
        set_poly(16'd19, 16'd0, 16'd0, 16'd5);
        run_eval(4'd1, 1'b0, 1'b0, r, lat);
        n_tests++; if (ok_all1 !== 1'b0) begin n_fail++; $display("FAIL chain_r3_ok_all got %b want 0", ok_all1); end
        n_tests++; if (fail1 !== 1'b1) begin n_fail++; $display("FAIL chain_r3_fail got %b want 1", fail1); end
        set_poly(16'd19, 16'd0, 16'd0, 16'd38);
        run_eval(4'd1, 1'b0, 1'b0, r, lat);
        n_tests++; if (ok_all1 !== 1'b1) begin n_fail++; $display("FAIL chain_r4_ok_all got %b want 1", ok_all1); end
        n_tests++; if (fail1 !== 1'b1) begin n_fail++; $display("FAIL chain_r4_sticky got %b want 1", fail1); end
        run_eval(4'd1, 1'b1, 1'b0, r, lat);
        n_tests++; if (fail1 !== 1'b0) begin n_fail++; $display("FAIL chain_r5_restart got %b want 0", fail1); end
    endtask

    task automatic test_back_to_back;
        int lat;
        set_poly(16'd3, 16'd2, 16'd1, 16'd9); tau = 16'd5;
        @(negedge clk); ncoeff = 4'd2; restart = 1'b0; chain = 1'b0; en = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!ready1 && lat < 200) begin @(posedge clk); #1; lat++; end
        n_tests++; if (val_out1[1] !== 16'd38) begin n_fail++; $display("FAIL b2b_first_val got %0d want 38", val_out1[1]); end
        @(negedge clk);
        set_poly(16'd19, 16'd0, 16'd0, 16'd0); ncoeff = 4'd1; chain = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (ready1 !== 1'b0) begin n_fail++; $display("FAIL b2b_accept got ready %b want 0", ready1); end
        en = 1'b0;
        lat = 0;
        while (!ready1 && lat < 200) begin @(posedge clk); #1; lat++; end
        n_tests++; if (lat != 3) begin n_fail++; $display("FAIL b2b_latency got %0d want 3", lat); end
        n_tests++; if (ok_all1 !== 1'b1) begin n_fail++; $display("FAIL b2b_ok_all got %b want 1", ok_all1); end
        chain = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic r; int lat;
        set_poly(16'd3, 16'd2, 16'd1, 16'd1); tau = 16'd5;
        run_eval(4'd2, 1'b0, 1'b0, r, lat);
        n_tests++; if (fail1 !== 1'b1) begin n_fail++; $display("FAIL rmid_setup_fail got %b want 1", fail1); end
        @(negedge clk); ncoeff = 4'd9; en = 1'b1;
        @(posedge clk); #1; en = 1'b0;
        rstb = 1'b1;
        #1;
        n_tests++; if (ready1 !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got %b want 1", ready1); end
        n_tests++; if (val_out1[0] !== 16'd0) begin n_fail++; $display("FAIL rmid_val got %0d want 0", val_out1[0]); end
        n_tests++; if (ok1 !== 4'h0) begin n_fail++; $display("FAIL rmid_ok got %h want 0", ok1); end
        n_tests++; if (fail1 !== 1'b0) begin n_fail++; $display("FAIL rmid_fail got %b want 0", fail1); end
        @(negedge clk); rstb = 1'b0;
    endtask

    task automatic test_lanes;
        int lat;
        int ev [4];
        int e2 [4];
        for (int l = 0; l < 4; l++)
            for (int j = 0; j < 10; j++) c_in[l][j] = 16'($urandom_range(Q - 1, 0));
        tau = 16'($urandom_range(Q - 1, 0));
        for (int l = 0; l < 4; l++) begin
            ev[l] = model_val(l, 9, int'(tau));
            e2[l] = model_v2(l, 9);
            val_in[l] = 16'(e2[l]);
        end
        @(negedge clk); ncoeff = 4'd9; restart = 1'b1; chain = 1'b0; en3 = 1'b1;
        @(posedge clk); #1; en3 = 1'b0;
        lat = 0;
        while (!ready3 && lat < 300) begin @(posedge clk); #1; lat++; end
        n_tests++; if (lat != 37) begin n_fail++; $display("FAIL lanes_latency got %0d want 37", lat); end
        for (int l = 0; l < 4; l++) begin
            n_tests++; if (val_out3[l] !== 16'(ev[l])) begin n_fail++; $display("FAIL lanes_val[%0d] got %0d want %0d", l, val_out3[l], ev[l]); end
            n_tests++; if (v2_out3[l] !== 16'(e2[l])) begin n_fail++; $display("FAIL lanes_v2[%0d] got %0d want %0d", l, v2_out3[l], e2[l]); end
        end
        n_tests++; if (ok_all3 !== 1'b1) begin n_fail++; $display("FAIL lanes_ok_all got %b want 1", ok_all3); end
        restart = 1'b0;
    endtask

    initial begin
        set_poly(16'd0, 16'd0, 16'd0, 16'd0);
        test_reset();
        test_basic();
        test_wrap();
        test_degree0();
        test_clamp();
        test_busy();
        test_chain_fail();
        test_back_to_back();
        test_reset_mid();
        test_lanes();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
